// File: rtl/alu_core_seq.sv
// Self-sequenced ALU core: accepts one instruction over valid/ready, then runs IDLE->FETCH->EXEC->WB.
// Optional build macro OVERFLOW_TRAP_EN adds a sticky overflow trap that blocks the write and stalls intake.
module alu_core_seq #(
  parameter int DataSize = 32,
  parameter int AddrSize = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_valid,
  input  logic [31:0]         inst,
  output logic                inst_ready,
  output logic                done,
  output logic [DataSize-1:0] alu_result,
  output logic                alu_overflow,
  output logic                illegal,
  input  logic [AddrSize-1:0] dbg_addr,
  output logic [DataSize-1:0] dbg_data,
  output logic [1:0]          dbg_state
`ifdef OVERFLOW_TRAP_EN
  ,
  output logic                trap
`endif
);

  // Handshake: an instruction transfers on a rising edge where inst_valid && inst_ready;
  // inst_ready is high only in IDLE, and inst_valid is ignored in every other state.

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, EXEC = 2'd2, WB = 2'd3} state_t;

  localparam int MSB = DataSize - 1;
  localparam logic [5:0] OP_ALU  = 6'b100000;
  localparam logic [5:0] OP_MOVI = 6'b100010;
  localparam logic [5:0] OP_ADDI = 6'b101000;
  localparam logic [5:0] OP_ORI  = 6'b101100;
  localparam logic [5:0] OP_XORI = 6'b101011;

  state_t              state;
  logic [30:0]         inst_q;
  logic [DataSize-1:0] op_a;
  logic [DataSize-1:0] op_b;
  logic [DataSize-1:0] regs [2**AddrSize];
  logic                ill_q;
  logic                unused_inst_msb;

  logic [5:0]          opcode;
  logic [4:0]          sub_fn;
  logic [4:0]          imm5;
  logic [AddrSize-1:0] rt;
  logic [AddrSize-1:0] ra;
  logic [AddrSize-1:0] rb;
  logic [DataSize-1:0] se15;
  logic [DataSize-1:0] ze15;
  logic [DataSize-1:0] se20;
  logic [DataSize-1:0] sum_ab;
  logic [DataSize-1:0] diff_ab;
  logic [DataSize-1:0] sum_ai;
  logic [DataSize-1:0] rot_res;
  logic [31:0]         rot_amt;
  logic                ovf_add;
  logic                ovf_sub;
  logic                ovf_addi;

  logic [DataSize-1:0] exe_res;
  logic                exe_legal;
  logic                exe_ovf_upd;
  logic                exe_ovf;

  assign unused_inst_msb = inst[31];

  assign opcode = inst_q[30:25];
  assign sub_fn = inst_q[4:0];
  assign imm5   = inst_q[14:10];
  assign rt     = inst_q[20 +: AddrSize];
  assign ra     = inst_q[15 +: AddrSize];
  assign rb     = inst_q[10 +: AddrSize];

  assign se15 = {{(DataSize-15){inst_q[14]}}, inst_q[14:0]};
  assign ze15 = {{(DataSize-15){1'b0}}, inst_q[14:0]};
  assign se20 = {{(DataSize-20){inst_q[19]}}, inst_q[19:0]};

  assign sum_ab  = op_a + op_b;
  assign diff_ab = op_a - op_b;
  assign sum_ai  = op_a + se15;

  assign ovf_add  = (op_a[MSB] == op_b[MSB]) && (sum_ab[MSB] != op_a[MSB]);
  assign ovf_sub  = (op_a[MSB] != op_b[MSB]) && (diff_ab[MSB] != op_a[MSB]);
  assign ovf_addi = (op_a[MSB] == se15[MSB]) && (sum_ai[MSB] != op_a[MSB]);

  // A zero rotate amount makes the left-shift term shift by the full width, which yields zero.
  assign rot_amt = 32'(imm5) % 32'(DataSize);
  assign rot_res = (op_a >> rot_amt) | (op_a << (32'(DataSize) - rot_amt));

  always_comb begin
    exe_res     = alu_result;
    exe_legal   = 1'b1;
    exe_ovf_upd = 1'b0;
    exe_ovf     = 1'b0;
    case (opcode)
      OP_ALU: begin
        case (sub_fn)
          5'b00000: begin exe_res = sum_ab;  exe_ovf_upd = 1'b1; exe_ovf = ovf_add; end
          5'b00001: begin exe_res = diff_ab; exe_ovf_upd = 1'b1; exe_ovf = ovf_sub; end
          5'b00010: exe_res = op_a & op_b;
          5'b00100: exe_res = op_a | op_b;
          5'b00011: exe_res = op_a ^ op_b;
          5'b01001: exe_res = op_a >> imm5;
          5'b01000: exe_res = op_a << imm5;
          5'b01011: exe_res = rot_res;
          default:  exe_legal = 1'b0;
        endcase
      end
      OP_MOVI: exe_res = se20;
      OP_ADDI: begin exe_res = sum_ai; exe_ovf_upd = 1'b1; exe_ovf = ovf_addi; end
      OP_ORI:  exe_res = op_a | ze15;
      OP_XORI: exe_res = op_a ^ ze15;
      default: exe_legal = 1'b0;
    endcase
  end

`ifdef OVERFLOW_TRAP_EN
  logic ovf_q;
  assign inst_ready = (state == IDLE) && !trap;
`else
  assign inst_ready = (state == IDLE);
`endif

  assign dbg_data  = regs[dbg_addr];
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      inst_q       <= '0;
      op_a         <= '0;
      op_b         <= '0;
      alu_result   <= '0;
      alu_overflow <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
      ill_q        <= 1'b0;
      for (int i = 0; i < 2**AddrSize; i++) regs[i] <= '0;
`ifdef OVERFLOW_TRAP_EN
      ovf_q <= 1'b0;
      trap  <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (inst_valid && inst_ready) begin
            inst_q <= inst[30:0];
            state  <= FETCH;
          end
        end
        FETCH: begin
          op_a  <= regs[ra];
          op_b  <= regs[rb];
          state <= EXEC;
        end
        EXEC: begin
          alu_result <= exe_res;
          if (exe_ovf_upd) alu_overflow <= exe_ovf;
          ill_q <= !exe_legal;
`ifdef OVERFLOW_TRAP_EN
          ovf_q <= exe_ovf_upd && exe_ovf;
`endif
          state <= WB;
        end
        WB: begin
          done    <= 1'b1;
          illegal <= ill_q;
`ifdef OVERFLOW_TRAP_EN
          if (!ill_q && !ovf_q) regs[rt] <= alu_result;
          if (ovf_q) trap <= 1'b1;
`else
          if (!ill_q) regs[rt] <= alu_result;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_core_seq.sv
// Bench for alu_core_seq: directed plan plus random instructions against an arithmetic reference model.
// Honours OVERFLOW_TRAP_EN when the build defines it.
module tb_alu_core_seq;

  localparam longint MAXS = 64'sh7FFF_FFFF;
  localparam longint MINS = -MAXS - 1;
`ifdef OVERFLOW_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_valid = 1'b0;
  logic [31:0] inst = '0;
  logic        inst_ready;
  logic        done;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        illegal;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
  logic [1:0]  dbg_state;
`ifdef OVERFLOW_TRAP_EN
  logic        trap;
`endif

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_res;
  logic        m_ovf;
  logic        m_ill;
  logic        m_trap;

  alu_core_seq #(.DataSize(32), .AddrSize(5)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
    .done(done), .alu_result(alu_result), .alu_overflow(alu_overflow), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
`ifdef OVERFLOW_TRAP_EN
    , .trap(trap)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] sub, input logic [4:0] rt,
                                        input logic [4:0] ra, input logic [4:0] rb);
    return {1'b0, 6'b100000, rt, ra, rb, 5'b00000, sub};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] ra, input logic [14:0] imm);
    return {1'b0, op, rt, ra, imm};
  endfunction

  function automatic logic [31:0] movi(input logic [4:0] rt, input logic [19:0] imm);
    return {1'b0, 6'b100010, rt, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_res = '0; m_ovf = 1'b0; m_ill = 1'b0; m_trap = 1'b0;
  endtask

  // Reference semantics: signed arithmetic in 64 bits, overflow means the true result left the int32 range.
  task automatic model_exec(input logic [31:0] w);
    longint sa, sb, s, imm;
    logic [31:0] a, r;
    logic legal, has_ovf, o;
    int amt;
    a  = m_regs[w[19:15]];
    sa = longint'($signed(m_regs[w[19:15]]));
    sb = longint'($signed(m_regs[w[14:10]]));
    imm = w[14] ? longint'(w[14:0]) - 32768 : longint'(w[14:0]);
    amt = int'(w[14:10]);
    legal = 1'b1; has_ovf = 1'b0; o = 1'b0; r = '0; s = 0;
    case (w[30:25])
      6'b100000: begin
        case (w[4:0])
          5'b00000: begin s = sa + sb; r = s[31:0]; has_ovf = 1'b1; o = (s > MAXS) || (s < MINS); end
          5'b00001: begin s = sa - sb; r = s[31:0]; has_ovf = 1'b1; o = (s > MAXS) || (s < MINS); end
          5'b00010: r = a & m_regs[w[14:10]];
          5'b00100: r = a | m_regs[w[14:10]];
          5'b00011: r = a ^ m_regs[w[14:10]];
          5'b01001: r = a >> amt;
          5'b01000: r = a << amt;
          5'b01011: begin
            r = a;
            for (int i = 0; i < amt % 32; i++) r = {r[0], r[31:1]};
          end
          default: legal = 1'b0;
        endcase
      end
      6'b100010: begin
        s = w[19] ? longint'(w[19:0]) - 1048576 : longint'(w[19:0]);
        r = s[31:0];
      end
      6'b101000: begin s = sa + imm; r = s[31:0]; has_ovf = 1'b1; o = (s > MAXS) || (s < MINS); end
      6'b101100: r = a | {17'b0, w[14:0]};
      6'b101011: r = a ^ {17'b0, w[14:0]};
      default: legal = 1'b0;
    endcase
    m_ill = !legal;
    if (legal) begin
      m_res = r;
      if (has_ovf) m_ovf = o;
      if (TRAP_EN && has_ovf && o) m_trap = 1'b1;
      else m_regs[w[24:20]] = r;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; inst_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic check_reg(input string tag, input logic [4:0] a, input logic [31:0] v);
    @(negedge clk);
    dbg_addr = a;
    #1 check(tag, dbg_data, v);
  endtask

  task automatic full_compare(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      dbg_addr = 5'(i);
      #1 check(tag, dbg_data, m_regs[i]);
    end
  endtask

  // Issues one instruction and checks the retirement cycle exactly three edges after acceptance.
  task automatic run_inst(input logic [31:0] w, input bit hold);
    int waited;
    waited = 0;
    @(negedge clk);
    while (inst_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_issue", inst_ready, 1'b1);
    inst_valid = 1'b1;
    inst = w;
    @(posedge clk);
    #1;
    if (!hold) inst_valid = 1'b0;
    check("ready_busy", inst_ready, 1'b0);
    check("done_early1", done, 1'b0);
    @(posedge clk);
    #1 check("done_early2", done, 1'b0);
    @(posedge clk);
    #1 check("done_early3", done, 1'b0);
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
    model_exec(w);
    check("done_pulse", done, 1'b1);
    check("illegal", illegal, m_ill);
    check("alu_result", alu_result, m_res);
    check("alu_overflow", alu_overflow, m_ovf);
    check("ready_after", inst_ready, !m_trap);
`ifdef OVERFLOW_TRAP_EN
    check("trap", trap, m_trap);
`endif
    dbg_addr = w[24:20];
    #1 check("dbg_rt", dbg_data, m_regs[w[24:20]]);
  endtask

  task automatic plan(input string tag, input logic [31:0] w, input logic [31:0] v);
    run_inst(w, 1'b0);
    check(tag, alu_result, v);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [4:0] subs [8];
    int k;
    subs = '{5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b00011, 5'b01001, 5'b01000, 5'b01011};
    w = $urandom;
    k = $urandom_range(0, 13);
    if (k < 8) begin
      w[30:25] = 6'b100000; w[4:0] = subs[k];
    end else if (k == 8) w[30:25] = 6'b100010;
    else if (k == 9) w[30:25] = 6'b101000;
    else if (k == 10) w[30:25] = 6'b101100;
    else if (k == 11) w[30:25] = 6'b101011;
    else if (k == 12) begin
      while (w[30:25] inside {6'b100000, 6'b100010, 6'b101000, 6'b101100, 6'b101011})
        w[30:25] = 6'($urandom);
    end else begin
      w[30:25] = 6'b100000;
      while (w[4:0] inside {5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b00011, 5'b01001, 5'b01000, 5'b01011})
        w[4:0] = 5'($urandom);
    end
    return w;
  endfunction

  initial begin
    logic [31:0] w;
    model_reset();
    do_reset();
    check("rst_done", done, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_alu_result", alu_result, 32'h0);
    check("rst_alu_overflow", alu_overflow, 1'b0);
    check("rst_ready", inst_ready, 1'b1);
`ifdef OVERFLOW_TRAP_EN
    check("rst_trap", trap, 1'b0);
`endif
    full_compare("rst_regs");

    plan("movi_r0", movi(5'd0, 20'd200), 32'h0000_00C8);
    check("movi_ovf", alu_overflow, 1'b0);
    check_reg("plan_r0", 5'd0, 32'h0000_00C8);
    plan("addi_r1", itype(6'b101000, 5'd1, 5'd0, 15'd100), 32'h0000_012C);
    check_reg("plan_r1", 5'd1, 32'h0000_012C);
    plan("add_r2", rtype(5'b00000, 5'd2, 5'd0, 5'd1), 32'h0000_01F4);
    plan("sub_r2", rtype(5'b00001, 5'd2, 5'd1, 5'd0), 32'h0000_0064);
    check_reg("plan_r2_sub", 5'd2, 32'h0000_0064);
    plan("and", rtype(5'b00010, 5'd2, 5'd0, 5'd1), 32'h0000_0008);
    plan("or", rtype(5'b00100, 5'd2, 5'd0, 5'd1), 32'h0000_01EC);
    plan("xor", rtype(5'b00011, 5'd2, 5'd0, 5'd1), 32'h0000_01E4);
    plan("srli", rtype(5'b01001, 5'd2, 5'd0, 5'd3), 32'h0000_0019);
    plan("slli", rtype(5'b01000, 5'd2, 5'd0, 5'd3), 32'h0000_0640);
    plan("rotri", rtype(5'b01011, 5'd2, 5'd0, 5'd3), 32'h0000_0019);
    plan("rotri0", rtype(5'b01011, 5'd6, 5'd0, 5'd0), 32'h0000_00C8);
    plan("ori", itype(6'b101100, 5'd2, 5'd0, 15'd100), 32'h0000_00EC);
    plan("xori", itype(6'b101011, 5'd2, 5'd0, 15'd100), 32'h0000_00AC);

    w = 32'h7E00_0000 | 32'h0020_0000;
    run_inst(w, 1'b0);
    check("illegal_pulse", illegal, 1'b1);
    check("illegal_hold", alu_result, 32'h0000_00AC);
    full_compare("illegal_regs");

    plan("movi_r3", movi(5'd3, 20'h7FFFF), 32'h0007_FFFF);
    plan("slli_r3", rtype(5'b01000, 5'd3, 5'd3, 5'd12), 32'h7FFF_F000);
    plan("ori_r3", itype(6'b101100, 5'd3, 5'd3, 15'h0FFF), 32'h7FFF_FFFF);
    plan("addi_ovf", itype(6'b101000, 5'd4, 5'd3, 15'd1), 32'h8000_0000);
    check("addi_ovf_flag", alu_overflow, 1'b1);
    check_reg("plan_r4", 5'd4, TRAP_EN ? 32'h0 : 32'h8000_0000);
    if (m_trap) do_reset();

    plan("movi_r0b", movi(5'd0, 20'd200), 32'h0000_00C8);
    run_inst(movi(5'd1, 20'd300), 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("hold_single_accept", done, 1'b0);
    end

    @(negedge clk);
    inst_valid = 1'b1;
    inst = rtype(5'b00000, 5'd5, 5'd0, 5'd1);
    @(posedge clk);
    #1 inst_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check("rst_exec_done", done, 1'b0);
    check("rst_exec_ready", inst_ready, 1'b1);
    dbg_addr = 5'd5;
    #1 check("rst_exec_r5", dbg_data, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 check("rst_exec_no_done", done, 1'b0);
    end

    for (int n = 0; n < 200; n++) begin
      run_inst(rand_inst(), 1'($urandom_range(0, 1)));
      if (m_trap) do_reset();
      if (n % 50 == 49) full_compare("rand_regs");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
